// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Purpose  : Bundles the instruction-memory, hazard-control and IF/ID
//             pipeline-register signals of the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    // Fetch stage view: drives the PC and the IF/ID register.
    modport master (
        output pc_out,
        input  instr_in,
        input  stall,
        input  flush,
        input  redirect,
        input  redirect_pc,
        output if_id_instr,
        output if_id_pc,
        output if_id_pc4,
        output if_id_valid,
        output misalign_err,
        output fetch_count
    );

    // Environment view: memory, hazard unit and decode stage.
    modport slave (
        input  pc_out,
        output instr_in,
        output stall,
        output flush,
        output redirect,
        output redirect_pc,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_pc4,
        input  if_id_valid,
        input  misalign_err,
        input  fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch stage. Holds the PC, captures the instruction
//             returned by memory into IF/ID, and honours redirect, flush and
//             stall requests in that priority order.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    fetch_stage_if.master   bus
);

    localparam logic [31:0] c_pc_step   = 32'd4;
    localparam logic [31:0] c_count_max = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc4;
    logic        r_if_id_valid;
    logic        r_misalign_err;
    logic [31:0] r_fetch_count;

    // Sequential address; 32-bit add wraps naturally at the top of memory.
    logic [31:0] w_pc_next;
    assign w_pc_next = r_pc + c_pc_step;

    // PC register feeds memory directly so no input reaches pc_out combinationally.
    assign bus.pc_out       = r_pc;
    assign bus.if_id_instr  = r_if_id_instr;
    assign bus.if_id_pc     = r_if_id_pc;
    assign bus.if_id_pc4    = r_if_id_pc4;
    assign bus.if_id_valid  = r_if_id_valid;
    assign bus.misalign_err = r_misalign_err;
    assign bus.fetch_count  = r_fetch_count;

    // Boot/run control with PC and IF/ID update (redirect > flush > stall > normal).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_BOOT;
            r_pc           <= RESET_PC;
            r_if_id_instr  <= NOP_INSTR;
            r_if_id_pc     <= 32'd0;
            r_if_id_pc4    <= 32'd0;
            r_if_id_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
            r_fetch_count  <= 32'd0;
        end else if (r_state == S_BOOT) begin
            // One idle edge so memory sees RESET_PC before the first capture.
            r_state <= S_RUN;
        end else begin
            if (bus.redirect) begin
                // Target is word-aligned by dropping the low bits; the fault is latched.
                r_pc          <= {bus.redirect_pc[31:2], 2'b00};
                r_if_id_instr <= NOP_INSTR;
                r_if_id_pc    <= 32'd0;
                r_if_id_pc4   <= 32'd0;
                r_if_id_valid <= 1'b0;
                if (bus.redirect_pc[1:0] != 2'b00) begin
                    r_misalign_err <= 1'b1;
                end
            end else if (bus.flush) begin
                r_if_id_instr <= NOP_INSTR;
                r_if_id_pc    <= 32'd0;
                r_if_id_pc4   <= 32'd0;
                r_if_id_valid <= 1'b0;
                if (!bus.stall) begin
                    r_pc <= w_pc_next;
                end
            end else if (!bus.stall) begin
                r_pc          <= w_pc_next;
                r_if_id_instr <= bus.instr_in;
                r_if_id_pc    <= r_pc;
                r_if_id_pc4   <= w_pc_next;
                r_if_id_valid <= 1'b1;
                if (r_fetch_count != c_count_max) begin
                    r_fetch_count <= r_fetch_count + 32'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage with directed scenarios and
//             randomized traffic against a behavioural pipeline model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preloaded memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    always_comb bus.instr_in  = mem_word(bus.pc_out);
    always_comb bus2.instr_in = mem_word(bus2.pc_out);

    // Behavioural model of the first DUT.
    bit          m_boot;
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    logic        m_valid, m_mis;

    task automatic model_reset();
        m_boot = 1'b1; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
        m_ipc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic model_update();
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (bus.redirect) begin
            m_pc = bus.redirect_pc & ~32'd3;
            m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_valid = 1'b0;
            if (bus.redirect_pc % 4 != 0) m_mis = 1'b1;
        end else if (bus.flush) begin
            m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_valid = 1'b0;
            if (!bus.stall) m_pc = m_pc + 32'd4;
        end else if (!bus.stall) begin
            m_instr = mem_word(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
            m_valid = 1'b1; m_pc = m_pc + 32'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic s, input logic f, input logic r, input logic [31:0] rpc);
        bus.stall = s; bus.flush = f; bus.redirect = r; bus.redirect_pc = rpc;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.pc_out !== 32'h0) begin n_errors++; $display("FAIL reset_pc got %h expected %h", bus.pc_out, 32'h0); end
        n_checks++; if (bus.if_id_instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr got %h expected %h", bus.if_id_instr, 32'h0); end
        n_checks++; if (bus.if_id_pc !== 32'h0 || bus.if_id_pc4 !== 32'h0) begin n_errors++; $display("FAIL reset_ifid_pc got %h/%h expected 0/0", bus.if_id_pc, bus.if_id_pc4); end
        n_checks++; if (bus.if_id_valid !== 1'b0 || bus.misalign_err !== 1'b0) begin n_errors++; $display("FAIL reset_flags got valid=%b mis=%b expected 0/0", bus.if_id_valid, bus.misalign_err); end
        n_checks++; if (bus.fetch_count !== 32'h0) begin n_errors++; $display("FAIL reset_count got %h expected 0", bus.fetch_count); end
        n_checks++; if (bus2.pc_out !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL reset_pc_param got %h expected fffffffc", bus2.pc_out); end
    endtask

    task automatic test_boot_seq();
        set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();
        release_reset();
        step();
        n_checks++; if (bus.if_id_valid !== 1'b0 || bus.pc_out !== 32'h0) begin n_errors++; $display("FAIL boot_edge got valid=%b pc=%h expected 0/0", bus.if_id_valid, bus.pc_out); end
        step();
        n_checks++; if (bus.if_id_pc !== 32'h0 || bus.if_id_valid !== 1'b1) begin n_errors++; $display("FAIL first_capture got pc=%h valid=%b expected 0/1", bus.if_id_pc, bus.if_id_valid); end
        n_checks++; if (bus.if_id_instr !== mem_word(32'h0)) begin n_errors++; $display("FAIL first_instr got %h expected %h", bus.if_id_instr, mem_word(32'h0)); end
        step();
        n_checks++; if (bus.if_id_pc !== 32'h4 || bus.pc_out !== 32'h8 || bus.fetch_count !== 32'd2) begin n_errors++; $display("FAIL second_capture got ifpc=%h pc=%h cnt=%0d expected 4/8/2", bus.if_id_pc, bus.pc_out, bus.fetch_count); end
        n_checks++; if (bus.if_id_pc4 !== 32'h8) begin n_errors++; $display("FAIL second_pc4 got %h expected 8", bus.if_id_pc4); end
    endtask

    task automatic test_stall();
        set_inputs(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.pc_out !== 32'h8 || bus.if_id_pc !== 32'h4 || bus.if_id_instr !== mem_word(32'h4) || bus.fetch_count !== 32'd2 || bus.if_id_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_hold cyc %0d got pc=%h ifpc=%h cnt=%0d expected 8/4/2", i, bus.pc_out, bus.if_id_pc, bus.fetch_count);
            end
        end
        set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        n_checks++; if (bus.if_id_pc !== 32'h8 || bus.fetch_count !== 32'd3) begin n_errors++; $display("FAIL stall_release got ifpc=%h cnt=%0d expected 8/3", bus.if_id_pc, bus.fetch_count); end
    endtask

    task automatic test_redirect();
        set_inputs(1'b1, 1'b0, 1'b1, 32'h40);
        step();
        n_checks++; if (bus.pc_out !== 32'h40 || bus.if_id_valid !== 1'b0) begin n_errors++; $display("FAIL redirect_stall got pc=%h valid=%b expected 40/0", bus.pc_out, bus.if_id_valid); end
        n_checks++; if (bus.fetch_count !== 32'd3 || bus.if_id_instr !== 32'h0) begin n_errors++; $display("FAIL redirect_bubble got cnt=%0d instr=%h expected 3/0", bus.fetch_count, bus.if_id_instr); end
        set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        n_checks++; if (bus.if_id_pc !== 32'h40 || bus.if_id_pc4 !== 32'h44) begin n_errors++; $display("FAIL redirect_capture got %h/%h expected 40/44", bus.if_id_pc, bus.if_id_pc4); end
    endtask

    task automatic test_misalign();
        n_checks++; if (bus.misalign_err !== 1'b0) begin n_errors++; $display("FAIL misalign_pre got %b expected 0", bus.misalign_err); end
        set_inputs(1'b0, 1'b0, 1'b1, 32'h22);
        step();
        n_checks++; if (bus.pc_out !== 32'h20 || bus.misalign_err !== 1'b1) begin n_errors++; $display("FAIL misalign_set got pc=%h mis=%b expected 20/1", bus.pc_out, bus.misalign_err); end
        set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step();
        n_checks++; if (bus.misalign_err !== 1'b1 || bus.pc_out !== 32'h2C) begin n_errors++; $display("FAIL misalign_sticky got mis=%b pc=%h expected 1/2c", bus.misalign_err, bus.pc_out); end
    endtask

    task automatic test_flush();
        logic [31:0] cnt_before;
        set_inputs(1'b0, 1'b0, 1'b1, 32'h10);
        step();
        cnt_before = m_cnt;
        set_inputs(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        n_checks++; if (bus.if_id_valid !== 1'b0 || bus.pc_out !== 32'h14) begin n_errors++; $display("FAIL flush got valid=%b pc=%h expected 0/14", bus.if_id_valid, bus.pc_out); end
        n_checks++; if (bus.fetch_count !== cnt_before) begin n_errors++; $display("FAIL flush_count got %0d expected %0d", bus.fetch_count, cnt_before); end
        set_inputs(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        n_checks++; if (bus.pc_out !== 32'h14 || bus.if_id_valid !== 1'b0) begin n_errors++; $display("FAIL flush_stall got pc=%h valid=%b expected 14/0", bus.pc_out, bus.if_id_valid); end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        for (int c = 0; c < 400; c++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            set_inputs($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 7) == 0, rpc);
            step();
            n_checks++;
            if (bus.pc_out !== m_pc || bus.if_id_instr !== m_instr || bus.if_id_pc !== m_ipc ||
                bus.if_id_pc4 !== m_ipc4 || bus.if_id_valid !== m_valid ||
                bus.misalign_err !== m_mis || bus.fetch_count !== m_cnt) begin
                n_errors++;
                $display("FAIL random cyc %0d got pc=%h ins=%h ipc=%h ipc4=%h v=%b mis=%b cnt=%0d expected pc=%h ins=%h ipc=%h ipc4=%h v=%b mis=%b cnt=%0d",
                         c, bus.pc_out, bus.if_id_instr, bus.if_id_pc, bus.if_id_pc4, bus.if_id_valid, bus.misalign_err, bus.fetch_count,
                         m_pc, m_instr, m_ipc, m_ipc4, m_valid, m_mis, m_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        set_inputs(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        set_inputs(1'b1, 1'b0, 1'b1, 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.pc_out !== 32'h0 || bus.if_id_instr !== 32'h0 || bus.if_id_pc !== 32'h0 || bus.if_id_pc4 !== 32'h0 ||
            bus.if_id_valid !== 1'b0 || bus.misalign_err !== 1'b0 || bus.fetch_count !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset got pc=%h ins=%h ipc=%h v=%b mis=%b cnt=%0d expected all zero",
                     bus.pc_out, bus.if_id_instr, bus.if_id_pc, bus.if_id_valid, bus.misalign_err, bus.fetch_count);
        end
        model_reset();
        @(posedge clk);
        #1;
        set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        step();
        n_checks++; if (bus.if_id_valid !== 1'b0 || bus.pc_out !== 32'h0) begin n_errors++; $display("FAIL post_reset_boot got valid=%b pc=%h expected 0/0", bus.if_id_valid, bus.pc_out); end
        step();
        n_checks++; if (bus.if_id_pc !== 32'h0 || bus.if_id_valid !== 1'b1 || bus.fetch_count !== 32'd1) begin n_errors++; $display("FAIL post_reset_capture got ipc=%h v=%b cnt=%0d expected 0/1/1", bus.if_id_pc, bus.if_id_valid, bus.fetch_count); end
    endtask

    task automatic test_reset_pc_wrap();
        set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (bus2.pc_out !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_reset_pc got %h expected fffffffc", bus2.pc_out); end
        release_reset();
        step();
        step();
        n_checks++; if (bus2.if_id_pc !== 32'hFFFF_FFFC || bus2.if_id_pc4 !== 32'h0 || bus2.pc_out !== 32'h0) begin n_errors++; $display("FAIL wrap_capture got ipc=%h ipc4=%h pc=%h expected fffffffc/0/0", bus2.if_id_pc, bus2.if_id_pc4, bus2.pc_out); end
        n_checks++; if (bus2.if_id_instr !== mem_word(32'hFFFF_FFFC) || bus2.if_id_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_instr got %h v=%b expected %h/1", bus2.if_id_instr, bus2.if_id_valid, mem_word(32'hFFFF_FFFC)); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0, 32'h0);
        bus2.stall = 1'b0; bus2.flush = 1'b0; bus2.redirect = 1'b0; bus2.redirect_pc = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_boot_seq();
        test_stall();
        test_redirect();
        test_misalign();
        test_flush();
        test_random();
        test_async_reset();
        test_reset_pc_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, meaning the encoding loaded into IF/ID on a bubble.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port pc_out  output  32  byte address driven to the instruction memory.
REQ-007 Port instr_in  input  32  instruction returned combinationally by the instruction memory for pc_out.
REQ-008 Port stall  input  1  hazard unit hold request.
REQ-009 Port flush  input  1  squash the IF/ID contents.
REQ-010 Port redirect  input  1  taken branch/jump.
REQ-011 Port redirect_pc  input  32  branch/jump target.
REQ-012 Port if_id_instr  output  32  latched instruction.
REQ-013 Port if_id_pc  output  32  address of the latched instruction.
REQ-014 Port if_id_pc4  output  32  if_id_pc + 4.
REQ-015 Port if_id_valid  output  1  latched instruction is real (not a bubble).
REQ-016 Port misalign_err  output  1  sticky misaligned-redirect flag.
REQ-017 Port fetch_count  output  32  number of valid instructions captured.

Function
REQ-018 The block SHALL implement two states: BOOT (entered on reset) and RUN.
REQ-019 In BOOT, the block SHALL spend exactly one clock edge with all inputs ignored, all registers held, and pc_out = RESET_PC, then transition to RUN.
REQ-020 pc_out SHALL be driven directly from the PC register, with no combinational path from any input.
REQ-021 In RUN, per rising edge, the priority SHALL be: redirect > flush > stall > normal.
REQ-022 Normal (no redirect/flush/stall): IF/ID <= {instr_in, pc_out, pc_out+4, valid=1}; PC <= pc_out+4; fetch_count increments.
REQ-023 Stall only: PC, IF/ID and fetch_count SHALL hold their values.
REQ-024 Flush without redirect: IF/ID <= {NOP_INSTR, 0, 0, valid=0}; PC SHALL hold if stall=1, else advance by 4; fetch_count SHALL NOT increment.
REQ-025 Redirect (regardless of stall/flush): PC <= {redirect_pc[31:2], 2'b00}; IF/ID <= bubble as in REQ-024; fetch_count SHALL NOT increment.
REQ-026 Redirect with redirect_pc[1:0] != 0 SHALL set misalign_err, which SHALL stay 1 until reset.
REQ-027 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 SHALL wrap to 0, and if_id_pc4 SHALL wrap the same way.
REQ-028 fetch_count SHALL saturate at 32'hFFFF_FFFF.
REQ-029 Single-cycle fetch latency: an instruction at pc_out in cycle N SHALL appear on if_id_* after edge N.

Reset
REQ-030 On rst_n=0, the block SHALL immediately (asynchronously) set: state=BOOT, pc_out=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, if_id_valid=0, misalign_err=0, fetch_count=0.
REQ-031 Reset asserted mid-operation SHALL discard any pending redirect/stall effect; the first post-reset capture SHALL be from RESET_PC.
REQ-032 After rst_n rises, the first edge SHALL be the BOOT edge; the first valid capture SHALL occur on the second edge.

Verification
REQ-033 Reset release with memory preloaded and stall=0 -> edge1: valid=0; edge2: if_id_pc=0, valid=1, instr=mem[0]; edge3: if_id_pc=4, pc_out=8, fetch_count=2.
REQ-034 stall=1 for 3 cycles at pc_out=8 -> pc_out stays 8, IF/ID unchanged, fetch_count unchanged; on release the next capture has if_id_pc=8.
REQ-035 redirect=1 with redirect_pc=0x40 and stall=1 -> next edge: pc_out=0x40, valid=0; the following edge: if_id_pc=0x40, if_id_pc4=0x44.
REQ-036 redirect_pc=0x22 -> pc_out=0x20, misalign_err=1, which persists across later normal fetches until rst_n=0.
REQ-037 RESET_PC=32'hFFFF_FFFC -> first capture has if_id_pc=FFFF_FFFC and if_id_pc4=0; pc_out=0.
REQ-038 flush=1 with stall=0 at pc_out=0x10 -> valid=0, pc_out=0x14; rst_n pulsed low mid-stall -> all outputs immediately reach their REQ-030 values without waiting for clk.
